// File: rtl/aes128_pkg.sv
// Shared AES-128 helpers (GF(2^8) arithmetic, S-box, Rcon), register map and FSM states.
package aes128_pkg;

    localparam int unsigned ROUNDS  = 10;
    localparam int unsigned ROUND_W = 4;

    localparam logic [7:0] OFF_KEY    = 8'h00;
    localparam logic [7:0] OFF_PT     = 8'h10;
    localparam logic [7:0] OFF_CT     = 8'h20;
    localparam logic [7:0] OFF_CTRL   = 8'h30;
    localparam logic [7:0] OFF_STATUS = 8'h34;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [ROUND_W-1:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data,
                                                input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    // Word 0 is the most significant 32 bits (block bytes 0..3).
    function automatic logic [31:0] get_word(input logic [127:0] v, input logic [1:0] w);
        case (w)
            2'd0:    return v[127:96];
            2'd1:    return v[95:64];
            2'd2:    return v[63:32];
            default: return v[31:0];
        endcase
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] v, input logic [1:0] w,
                                              input logic [31:0] data, input logic [3:0] sel);
        logic [127:0] r;
        r = v;
        case (w)
            2'd0:    r[127:96] = merge_bytes(v[127:96], data, sel);
            2'd1:    r[95:64]  = merge_bytes(v[95:64], data, sel);
            2'd2:    r[63:32]  = merge_bytes(v[63:32], data, sel);
            default: r[31:0]   = merge_bytes(v[31:0], data, sel);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes128_wb_accel_if.sv
// Wishbone classic slave bus bundle for the AES accelerator.
interface aes128_wb_accel_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/aes128_round.sv
// One AES-128 encryption round plus the matching on-the-fly key expansion step.
module aes128_round
    import aes128_pkg::*;
(
    input  logic [127:0]        cur_state,
    input  logic [127:0]        cur_rk,
    input  logic [ROUND_W-1:0]  round,
    input  logic                final_round,
    output logic [127:0]        next_state_c,
    output logic [127:0]        next_rk_c
);
    logic [7:0]  sb [16];
    logic [7:0]  sr [16];
    logic [7:0]  mc [16];
    logic [31:0] temp;
    logic [7:0]  a0, a1, a2, a3;

    always_comb begin
        sb           = '{default: '0};
        sr           = '{default: '0};
        mc           = '{default: '0};
        next_state_c = '0;
        next_rk_c    = '0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;

        // Next round key: w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon, then chained XORs.
        temp = {sbox(cur_rk[23:16]), sbox(cur_rk[15:8]), sbox(cur_rk[7:0]), sbox(cur_rk[31:24])}
               ^ {rcon(round), 24'h0};
        next_rk_c[127:96] = cur_rk[127:96] ^ temp;
        next_rk_c[95:64]  = cur_rk[95:64]  ^ next_rk_c[127:96];
        next_rk_c[63:32]  = cur_rk[63:32]  ^ next_rk_c[95:64];
        next_rk_c[31:0]   = cur_rk[31:0]   ^ next_rk_c[63:32];

        for (int i = 0; i < 16; i++) sb[i] = sbox(cur_state[8*(15-i) +: 8]);

        // Byte i sits at row i%4, column i/4; row r rotates left by r.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
        end

        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c + 1];
            a2 = sr[4*c + 2];
            a3 = sr[4*c + 3];
            mc[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end

        for (int i = 0; i < 16; i++) begin
            next_state_c[8*(15-i) +: 8] = (final_round ? sr[i] : mc[i]) ^ next_rk_c[8*(15-i) +: 8];
        end
    end
endmodule

// File: rtl/aes128_wb_accel.sv
// AES-128 encrypt-only Wishbone slave: register file, bus decode and one-round-per-clock FSM.
// Define AES_IRQ_EN to add the irq_o completion interrupt (STATUS bit2, cleared via CTRL bit1).
module aes128_wb_accel
    import aes128_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    aes128_wb_accel_if.slave wbs
`ifdef AES_IRQ_EN
    ,
    output logic             irq_o
`endif
);
    logic [127:0]       key_q, pt_q, ct_q, state_q, rk_q;
    logic [127:0]       next_state_c, next_rk_c;
    logic [ROUND_W-1:0] round_q;
    fsm_e               fsm_q;
    logic               done_q, ack_q, irq_c;
    logic [31:0]        dat_q, rdata_c;
    logic [7:0]         off_c;
    logic               hit_c, acc_c, wr_c, busy_c, ctrl_wr_c, final_c;
    logic               unused_adr_ok;

    assign off_c     = wbs.wbs_adr_i[7:0];
    assign hit_c     = wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8];
    // A request is served only when no ack was given last cycle, so acks never run back to back.
    assign acc_c     = wbs.wbs_cyc_i & wbs.wbs_stb_i & hit_c & ~ack_q;
    assign wr_c      = acc_c & wbs.wbs_we_i;
    assign ctrl_wr_c = wr_c & (off_c[7:2] == OFF_CTRL[7:2]) & wbs.wbs_sel_i[0];
    assign busy_c    = fsm_q == ST_RUN;
    assign final_c   = round_q == ROUND_W'(ROUNDS);
    assign unused_adr_ok = ^wbs.wbs_adr_i[1:0];

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;

    aes128_round u_round (
        .cur_state    (state_q),
        .cur_rk       (rk_q),
        .round        (round_q),
        .final_round  (final_c),
        .next_state_c (next_state_c),
        .next_rk_c    (next_rk_c)
    );

    always_comb begin
        rdata_c = '0;
        case (off_c[7:4])
            OFF_KEY[7:4]: rdata_c = get_word(key_q, off_c[3:2]);
            OFF_PT[7:4]:  rdata_c = get_word(pt_q, off_c[3:2]);
            OFF_CT[7:4]:  rdata_c = get_word(ct_q, off_c[3:2]);
            default: begin
                if (off_c[7:2] == OFF_STATUS[7:2]) rdata_c = {29'd0, irq_c, done_q, busy_c};
            end
        endcase
    end

`ifdef AES_IRQ_EN
    logic irq_q;
    assign irq_o = irq_q;
    assign irq_c = irq_q;
`else
    assign irq_c = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            key_q   <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
            state_q <= '0;
            rk_q    <= '0;
            round_q <= '0;
            fsm_q   <= ST_IDLE;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
`ifdef AES_IRQ_EN
            irq_q   <= 1'b0;
`endif
        end else begin
            ack_q <= acc_c;
            dat_q <= (acc_c && !wbs.wbs_we_i) ? rdata_c : '0;

            // Operand and start writes are dropped (but still acked) while a block is in flight.
            if (wr_c && !busy_c) begin
                if (off_c[7:4] == OFF_KEY[7:4])
                    key_q <= put_word(key_q, off_c[3:2], wbs.wbs_dat_i, wbs.wbs_sel_i);
                if (off_c[7:4] == OFF_PT[7:4])
                    pt_q <= put_word(pt_q, off_c[3:2], wbs.wbs_dat_i, wbs.wbs_sel_i);
                if (ctrl_wr_c && wbs.wbs_dat_i[0]) begin
                    state_q <= pt_q ^ key_q;
                    rk_q    <= key_q;
                    round_q <= ROUND_W'(1);
                    done_q  <= 1'b0;
                    fsm_q   <= ST_RUN;
                end
            end

`ifdef AES_IRQ_EN
            if (ctrl_wr_c && wbs.wbs_dat_i[1]) irq_q <= 1'b0;
`endif

            if (busy_c) begin
                state_q <= next_state_c;
                rk_q    <= next_rk_c;
                if (final_c) begin
                    ct_q   <= next_state_c;
                    done_q <= 1'b1;
                    fsm_q  <= ST_IDLE;
`ifdef AES_IRQ_EN
                    irq_q  <= 1'b1;
`endif
                end else begin
                    round_q <= round_q + ROUND_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_aes128_wb_accel.sv
// Self-checking bench for aes128_wb_accel: known-answer vectors, bus corner cases, busy/reset sequences.
module tb_aes128_wb_accel;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h30;
    localparam logic [31:0] A_STATUS = BASE + 32'h34;
`ifdef AES_IRQ_EN
    localparam logic [31:0] DONE_ST = 32'h6;
`else
    localparam logic [31:0] DONE_ST = 32'h2;
`endif

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_err = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[3];

    aes128_wb_accel_if wbs ();
`ifdef AES_IRQ_EN
    logic irq;
`endif

    aes128_wb_accel dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (wbs)
`ifdef AES_IRQ_EN
        ,
        .irq_o    (irq)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        wbs.wbs_sel_i = 4'h0;
        wbs.wbs_adr_i = '0;
        wbs.wbs_dat_i = '0;
    endtask

    // Drives one transaction; ack_cyc is the cycle count of the acking edge, or -1 on timeout.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd, output int ack_cyc);
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i  = we;
        wbs.wbs_sel_i = sel;
        wbs.wbs_adr_i = adr;
        wbs.wbs_dat_i = dat;
        ack_cyc = -1;
        rd = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (wbs.wbs_ack_o) begin
                ack_cyc = cyc_cnt;
                rd = wbs.wbs_dat_o;
                break;
            end
        end
        bus_idle();
    endtask

    task automatic wb_write(input string name, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output int ack_cyc);
        logic [31:0] rd;
        wb_xfer(1'b1, adr, dat, sel, rd, ack_cyc);
        if (ack_cyc < 0) check_eq({name, " write ack"}, 32'(ack_cyc >= 0), 32'd1);
    endtask

    task automatic rd_check(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        logic [31:0] e;
        int a;
        exp_q.push_back(exp);
        wb_xfer(1'b0, adr, '0, 4'hf, rd, a);
        e = exp_q.pop_front();
        if (a < 0) check_eq({name, " read ack"}, 32'(a >= 0), 32'd1);
        else check_eq(name, rd, e);
    endtask

    task automatic load_vec(input vec_t v);
        int a;
        for (int i = 0; i < 4; i++) begin
            wb_write("key", BASE + 32'(4*i), v.key[32*(3-i) +: 32], 4'hf, a);
            wb_write("pt", BASE + 32'h10 + 32'(4*i), v.pt[32*(3-i) +: 32], 4'hf, a);
        end
    endtask

    // Polls STATUS; each sample reflects register state after the edge before its ack.
    task automatic poll_done(input string name, input int start_cyc);
        logic [31:0] rd;
        logic [31:0] exp;
        int a;
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            wb_xfer(1'b0, A_STATUS, '0, 4'hf, rd, a);
            if (a < 0) break;
            exp = ((a - 1 - start_cyc) < 10) ? 32'h1 : DONE_ST;
            check_eq({name, " status"}, rd, exp);
            if (exp == DONE_ST) seen = 1'b1;
        end
        check_eq({name, " done seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_ct(input string name, input logic [127:0] ct);
        for (int i = 0; i < 4; i++)
            rd_check($sformatf("%s ct%0d", name, i), BASE + 32'h20 + 32'(4*i), ct[32*(3-i) +: 32]);
    endtask

    initial begin
        int a;
        int s;
        logic [31:0] rd;
        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        bus_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("reset ack", 32'(wbs.wbs_ack_o), 32'd0);
        check_eq("reset dat", wbs.wbs_dat_o, 32'd0);
        rd_check("reset status", A_STATUS, 32'd0);
        rd_check("reset key0", BASE, 32'd0);
        rd_check("reset pt3", BASE + 32'h1c, 32'd0);
        rd_check("reset ct0", BASE + 32'h20, 32'd0);

        // Byte-lane writes and unmapped reads.
        wb_write("key0 clr", BASE, 32'h0, 4'hf, a);
        wb_write("key0 lane", BASE, 32'hffff_ffff, 4'b0001, a);
        rd_check("key0 lane", BASE, 32'h0000_00ff);
        wb_write("pt3 lane", BASE + 32'h1c, 32'ha5a5_a5a5, 4'b1000, a);
        rd_check("pt3 lane", BASE + 32'h1c, 32'ha500_0000);
        rd_check("ctrl reads 0", A_CTRL, 32'd0);
        rd_check("unmapped reads 0", BASE + 32'h38, 32'd0);
        wb_xfer(1'b0, BASE + 32'h100, '0, 4'hf, rd, a);
        check_eq("off-base no ack", 32'(a < 0), 32'd1);
        check_eq("idle dat zero", wbs.wbs_dat_o, 32'd0);

        // Known-answer vectors.
        for (int v = 0; v < 3; v++) begin
            load_vec(vecs[v]);
            wb_write("start", A_CTRL, 32'h1, 4'h1, s);
            poll_done($sformatf("vec%0d", v), s);
            check_ct($sformatf("vec%0d", v), vecs[v].ct);
        end

        // Second start and key write during a run are ignored; CT holds the previous result.
        load_vec(vecs[0]);
        wb_write("start", A_CTRL, 32'h1, 4'h1, s);
        wb_write("restart", A_CTRL, 32'h1, 4'h1, a);
        wb_write("busy key", BASE, 32'hdead_beef, 4'hf, a);
        rd_check("busy ct hold", BASE + 32'h20, vecs[2].ct[127:96]);
        poll_done("busy", s);
        check_ct("busy", vecs[0].ct);
        rd_check("busy key kept", BASE, vecs[0].key[127:96]);

`ifdef AES_IRQ_EN
        check_eq("irq set", 32'(irq), 32'd1);
        wb_write("irq clr", A_CTRL, 32'h2, 4'h1, a);
        @(posedge clk);
        #1 check_eq("irq cleared", 32'(irq), 32'd0);
        rd_check("status after clr", A_STATUS, 32'h2);
`endif

        // Reset in the middle of a run aborts it and clears CT.
        load_vec(vecs[1]);
        wb_write("start", A_CTRL, 32'h1, 4'h1, s);
        rd_check("midrun busy", A_STATUS, 32'h1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rd_check("post-rst status", A_STATUS, 32'd0);
        check_ct("post-rst", 128'h0);
        rd_check("post-rst key0", BASE, 32'd0);
        load_vec(vecs[1]);
        wb_write("start", A_CTRL, 32'h1, 4'h1, s);
        poll_done("rerun", s);
        check_ct("rerun", vecs[1].ct);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
